voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter VOICES, default 32, meaning the number of polyphonic voices.
REQ-002 SHALL have parameter V_WIDTH, default utils::clogb2(VOICES), meaning the voice address width.
REQ-003 SHALL have parameter CHANNELS, default 4, meaning the number of multitimbral MIDI parts; CH_WIDTH = utils::clogb2(CHANNELS).
REQ-004 SHALL have parameter STEAL_MODE, default 1, meaning 1 = steal the oldest voice when full and 0 = drop the note.
REQ-005 SHALL use one clock and an asynchronous active-low reset; ports reg_clk and reset_reg_N.
REQ-006 SHALL have these ports:
- reg_clk  in  1  system clock
- reset_reg_N  in  1  async active-low reset
- note_on_req  in  1  note-on event strobe
- note_off_req  in  1  note-off event strobe
- evt_ch  in  CH_WIDTH  event part
- evt_key  in  7  event key
- evt_vel  in  7  event velocity
- evt_ready  out  1  allocator idle, may accept
- all_notes_off  in  1  panic strobe
- voice_free  in  VOICES  per-voice engine idle flags
- note_on  out  1  one-cycle voice-start pulse
- note_off  out  1  one-cycle voice-release pulse
- cur_key_adr  out  V_WIDTH  target voice
- cur_key_val  out  8  {1'b0,key}
- cur_vel  out  8  {1'b0,vel}
- cur_ch  out  CH_WIDTH  part of target voice
- keys_on  out  VOICES  per-voice gate
- active_keys  out  V_WIDTH+1  popcount of keys_on
- steal  out  1  pulse with note_on when a gated voice was stolen
- alloc_fail  out  1  pulse when a note-on is dropped
- off_note_error  out  1  pulse when a note-off matches no voice

Function
REQ-007 SHALL implement FSM IDLE -> SCAN -> ISSUE -> IDLE; evt_ready=1 only in IDLE.
REQ-008 SHALL accept an event in the cycle a strobe is high and evt_ready=1, latching ch/key/vel; strobes seen while not ready SHALL be ignored.
REQ-009 SHALL, when note_on_req and note_off_req are both high at accept, process note-off only and discard the note-on.
REQ-010 SHALL treat a note-on with evt_vel=0 as a note-off.
REQ-011 SCAN SHALL examine one voice per cycle, index 0..VOICES-1, lasting exactly VOICES cycles; ISSUE is 1 cycle; output pulse latency from accept = VOICES+1 cycles.
REQ-012 Per voice SHALL store key(7), ch(CH_WIDTH), age(V_WIDTH+1, saturating).
REQ-013 Note-on priority: (a) voice with keys_on=1 and matching ch+key (retrigger); (b) lowest-index voice with keys_on=0 and voice_free=1; (c) STEAL_MODE=1: voice with maximum age, ties to lowest index; else drop.
REQ-014 On an assigned note-on in ISSUE: set keys_on[v], store key/ch, age[v]=0, and increment every other voice with keys_on=1 by 1, saturating at all-ones; pulse note_on with cur_* = assigned voice.
REQ-015 steal SHALL pulse with note_on only under rule (c) when the victim had keys_on=1.
REQ-016 On a drop, SHALL pulse alloc_fail in ISSUE with no note_on and no state change.
REQ-017 Note-off SHALL clear keys_on of the unique voice with keys_on=1 and matching ch+key, pulsing note_off with cur_* = that voice; no match -> off_note_error pulse, keys_on unchanged.
REQ-018 all_notes_off in IDLE SHALL clear all keys_on in one cycle, without note_off pulses, and take priority over a simultaneous event strobe, which is discarded; in other states it SHALL be held pending until IDLE.
REQ-019 active_keys SHALL be registered, updating the cycle after keys_on changes.
REQ-020 voice_free SHALL be sampled during SCAN only; changes after a voice is scanned SHALL NOT affect the current decision.
REQ-021 cur_* SHALL hold their last values between pulses.

Reset
REQ-022 Asserting reset_reg_N low SHALL immediately set FSM=IDLE and keys_on=0, all ages=0, and all stored keys/ch=0.
REQ-023 The same reset SHALL clear note_on, note_off, steal, alloc_fail, off_note_error, cur_*, active_keys and any pending panic, and abort any in-progress scan without issuing.

Verification
REQ-024 VOICES=4, all voice_free=1: note-on ch0 key60 vel100 -> note_on at accept+5, cur_key_adr=0, cur_key_val=60, keys_on=0001, active_keys=1 one cycle later.
REQ-025 Fill 4 voices with keys 60..63, then key64 with STEAL_MODE=1 -> voice 0 reassigned with steal=1; repeat with STEAL_MODE=0 -> alloc_fail=1 and keys_on stays 1111.
REQ-026 Note-on ch1 key60 while ch0 key60 is held -> a new voice is used; repeat ch0 key60 -> retrigger of the same voice, active_keys unchanged.
REQ-027 Note-off ch2 key70 with no match -> off_note_error pulse; note-on key60 vel0 -> note_off for the voice holding key60.
REQ-028 Simultaneous on/off strobes -> only note-off processed; all_notes_off during SCAN -> keys_on=0 the cycle after returning to IDLE; reset mid-SCAN -> no pulse and keys_on=0.

Source files
------------

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Assigns MIDI note events to a pool of synthesiser voices. Each accepted event
// is resolved by a sequential scan over all voices (one voice per clock),
// followed by a single issue cycle that updates the voice table and emits a
// one-cycle pulse. The pulse appears VOICES+1 cycles after acceptance.
//
// Note-on priority: retrigger a gated voice already playing the same part+key,
// else the lowest-index idle voice (gate off and engine reports free), else
// (STEAL_MODE=1) the voice with the greatest age, ties to the lowest index,
// else the note is dropped.
//
// Ports
//   reg_clk, reset_reg_N      clock, asynchronous active-low reset
//   note_on_req/note_off_req  event strobes, accepted while evt_ready=1
//   evt_ch/evt_key/evt_vel    event part, key and velocity
//   evt_ready                 allocator idle and able to accept an event
//   all_notes_off             panic strobe: clears every gate (deferred to IDLE)
//   voice_free                per-voice engine idle flags, sampled while scanning
//   note_on/note_off          one-cycle voice start / release pulses
//   cur_key_adr/val, cur_vel, cur_ch   target voice info, held between pulses
//   keys_on                   per-voice gate
//   active_keys               registered popcount of keys_on
//   steal                     with note_on when a gated voice was taken over
//   alloc_fail                note-on dropped
//   off_note_error            note-off matched no gated voice
// -----------------------------------------------------------------------------
package utils;
    // Address width for n items; never narrower than one bit.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

module voice_allocator #(
    parameter int VOICES     = 32,
    parameter int V_WIDTH    = utils::clogb2(VOICES),
    parameter int CHANNELS   = 4,
    parameter int STEAL_MODE = 1,
    localparam int CH_WIDTH  = utils::clogb2(CHANNELS)
) (
    input  logic                reg_clk,
    input  logic                reset_reg_N,
    input  logic                note_on_req,
    input  logic                note_off_req,
    input  logic [CH_WIDTH-1:0] evt_ch,
    input  logic [6:0]          evt_key,
    input  logic [6:0]          evt_vel,
    output logic                evt_ready,
    input  logic                all_notes_off,
    input  logic [VOICES-1:0]   voice_free,
    output logic                note_on,
    output logic                note_off,
    output logic [V_WIDTH-1:0]  cur_key_adr,
    output logic [7:0]          cur_key_val,
    output logic [7:0]          cur_vel,
    output logic [CH_WIDTH-1:0] cur_ch,
    output logic [VOICES-1:0]   keys_on,
    output logic [V_WIDTH:0]    active_keys,
    output logic                steal,
    output logic                alloc_fail,
    output logic                off_note_error
);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE} state_t;

    localparam logic [V_WIDTH:0] AGE_MAX = '1;

    state_t                state;

    // Voice table
    logic [6:0]            voice_key [VOICES];
    logic [CH_WIDTH-1:0]   voice_ch  [VOICES];
    logic [V_WIDTH:0]      voice_age [VOICES];

    // Latched event
    logic [CH_WIDTH-1:0]   ev_ch;
    logic [6:0]            ev_key;
    logic [6:0]            ev_vel;
    logic                  ev_off;

    // Scan results accumulated one voice per cycle
    logic [V_WIDTH-1:0]    scan_idx;
    logic                  match_found;
    logic [V_WIDTH-1:0]    match_idx;
    logic                  free_found;
    logic [V_WIDTH-1:0]    free_idx;
    logic [V_WIDTH-1:0]    oldest_idx;
    logic [V_WIDTH:0]      oldest_age;

    logic                  panic_pending;

    logic                  scan_gated;
    logic                  scan_hit;
    logic                  tgt_valid;
    logic [V_WIDTH-1:0]    tgt_idx;
    logic                  tgt_steal;
    logic [V_WIDTH:0]      on_count;

    function automatic logic [V_WIDTH:0] age_inc(input logic [V_WIDTH:0] a);
        return (a == AGE_MAX) ? a : a + 1'b1;
    endfunction

    // A deferred panic also blocks acceptance so the discarded strobe is
    // never mistaken for an accepted one.
    assign evt_ready = (state == IDLE) && !panic_pending;

    assign scan_gated = keys_on[scan_idx];
    assign scan_hit   = scan_gated && (voice_key[scan_idx] == ev_key)
                                   && (voice_ch[scan_idx] == ev_ch);

    // Note-on target selection from the completed scan.
    always_comb begin
        tgt_valid = 1'b0;
        tgt_idx   = match_idx;
        tgt_steal = 1'b0;
        if (match_found) begin
            tgt_valid = 1'b1;
        end else if (free_found) begin
            tgt_valid = 1'b1;
            tgt_idx   = free_idx;
        end else if (STEAL_MODE != 0) begin
            tgt_valid = 1'b1;
            tgt_idx   = oldest_idx;
            tgt_steal = keys_on[oldest_idx];
        end
    end

    always_comb begin
        on_count = '0;
        for (int v = 0; v < VOICES; v++) begin
            on_count = on_count + {{V_WIDTH{1'b0}}, keys_on[v]};
        end
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            active_keys <= '0;
        end else begin
            active_keys <= on_count;
        end
    end

    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state          <= IDLE;
            keys_on        <= '0;
            for (int v = 0; v < VOICES; v++) begin
                voice_key[v] <= '0;
                voice_ch[v]  <= '0;
                voice_age[v] <= '0;
            end
            ev_ch          <= '0;
            ev_key         <= '0;
            ev_vel         <= '0;
            ev_off         <= 1'b0;
            scan_idx       <= '0;
            match_found    <= 1'b0;
            match_idx      <= '0;
            free_found     <= 1'b0;
            free_idx       <= '0;
            oldest_idx     <= '0;
            oldest_age     <= '0;
            panic_pending  <= 1'b0;
            note_on        <= 1'b0;
            note_off       <= 1'b0;
            steal          <= 1'b0;
            alloc_fail     <= 1'b0;
            off_note_error <= 1'b0;
            cur_key_adr    <= '0;
            cur_key_val    <= '0;
            cur_vel        <= '0;
            cur_ch         <= '0;
        end else begin
            note_on        <= 1'b0;
            note_off       <= 1'b0;
            steal          <= 1'b0;
            alloc_fail     <= 1'b0;
            off_note_error <= 1'b0;

            if (state != IDLE && all_notes_off) begin
                panic_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (all_notes_off || panic_pending) begin
                        keys_on       <= '0;
                        panic_pending <= 1'b0;
                    end else if (note_on_req || note_off_req) begin
                        ev_ch       <= evt_ch;
                        ev_key      <= evt_key;
                        ev_vel      <= evt_vel;
                        // Note-off wins over a simultaneous note-on; vel 0 means off.
                        ev_off      <= note_off_req || (evt_vel == 7'd0);
                        scan_idx    <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        state       <= SCAN;
                    end
                end

                SCAN: begin
                    if (scan_hit && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= scan_idx;
                    end
                    if (!scan_gated && voice_free[scan_idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= scan_idx;
                    end
                    // Strictly-greater keeps the lowest index on equal ages.
                    if (scan_idx == '0 || voice_age[scan_idx] > oldest_age) begin
                        oldest_age <= voice_age[scan_idx];
                        oldest_idx <= scan_idx;
                    end
                    if (scan_idx == V_WIDTH'(VOICES - 1)) begin
                        state <= ISSUE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end

                ISSUE: begin
                    state <= IDLE;
                    if (ev_off) begin
                        if (match_found) begin
                            keys_on[match_idx] <= 1'b0;
                            note_off           <= 1'b1;
                            cur_key_adr        <= match_idx;
                            cur_key_val        <= {1'b0, ev_key};
                            cur_vel            <= {1'b0, ev_vel};
                            cur_ch             <= ev_ch;
                        end else begin
                            off_note_error <= 1'b1;
                        end
                    end else if (tgt_valid) begin
                        for (int v = 0; v < VOICES; v++) begin
                            if (v == int'(tgt_idx)) begin
                                keys_on[v]   <= 1'b1;
                                voice_key[v] <= ev_key;
                                voice_ch[v]  <= ev_ch;
                                voice_age[v] <= '0;
                            end else if (keys_on[v]) begin
                                voice_age[v] <= age_inc(voice_age[v]);
                            end
                        end
                        note_on     <= 1'b1;
                        steal       <= tgt_steal;
                        cur_key_adr <= tgt_idx;
                        cur_key_val <= {1'b0, ev_key};
                        cur_vel     <= {1'b0, ev_vel};
                        cur_ch      <= ev_ch;
                    end else begin
                        alloc_fail <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//
// Two allocators (index 0: STEAL_MODE=1, index 1: STEAL_MODE=0) with four
// voices share one stimulus stream. A reference model of the voice table is
// updated per event from the allocation rules and compared with both devices.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

    localparam int NV      = 4;
    localparam int VW      = 2;
    localparam int AGE_MAX = 7;

    logic             reg_clk;
    logic             reset_reg_N;
    logic             note_on_req;
    logic             note_off_req;
    logic             all_notes_off;
    logic [1:0]       evt_ch;
    logic [6:0]       evt_key;
    logic [6:0]       evt_vel;
    logic [NV-1:0]    voice_free;

    logic [1:0]          evt_ready_o;
    logic [1:0]          note_on_o;
    logic [1:0]          note_off_o;
    logic [1:0]          steal_o;
    logic [1:0]          fail_o;
    logic [1:0]          oerr_o;
    logic [1:0][VW-1:0]  adr_o;
    logic [1:0][7:0]     kval_o;
    logic [1:0][7:0]     vel_o;
    logic [1:0][1:0]     ch_o;
    logic [1:0][NV-1:0]  keys_o;
    logic [1:0][VW:0]    act_o;

    int compared;
    int mismatched;

    // Reference voice table per device
    bit   md_on  [2][NV];
    int   md_key [2][NV];
    int   md_ch  [2][NV];
    int   md_age [2][NV];
    logic [4:0] ep [2];
    int   e_adr [2];
    int   e_key [2];
    int   e_vel [2];
    int   e_ch  [2];

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    voice_allocator #(.VOICES(NV), .CHANNELS(4), .STEAL_MODE(1)) dut_steal (
        .reg_clk(reg_clk), .reset_reg_N(reset_reg_N),
        .note_on_req(note_on_req), .note_off_req(note_off_req),
        .evt_ch(evt_ch), .evt_key(evt_key), .evt_vel(evt_vel),
        .evt_ready(evt_ready_o[0]), .all_notes_off(all_notes_off),
        .voice_free(voice_free), .note_on(note_on_o[0]), .note_off(note_off_o[0]),
        .cur_key_adr(adr_o[0]), .cur_key_val(kval_o[0]), .cur_vel(vel_o[0]),
        .cur_ch(ch_o[0]), .keys_on(keys_o[0]), .active_keys(act_o[0]),
        .steal(steal_o[0]), .alloc_fail(fail_o[0]), .off_note_error(oerr_o[0])
    );

    voice_allocator #(.VOICES(NV), .CHANNELS(4), .STEAL_MODE(0)) dut_drop (
        .reg_clk(reg_clk), .reset_reg_N(reset_reg_N),
        .note_on_req(note_on_req), .note_off_req(note_off_req),
        .evt_ch(evt_ch), .evt_key(evt_key), .evt_vel(evt_vel),
        .evt_ready(evt_ready_o[1]), .all_notes_off(all_notes_off),
        .voice_free(voice_free), .note_on(note_on_o[1]), .note_off(note_off_o[1]),
        .cur_key_adr(adr_o[1]), .cur_key_val(kval_o[1]), .cur_vel(vel_o[1]),
        .cur_ch(ch_o[1]), .keys_on(keys_o[1]), .active_keys(act_o[1]),
        .steal(steal_o[1]), .alloc_fail(fail_o[1]), .off_note_error(oerr_o[1])
    );

    function automatic logic [4:0] pulses(input int m);
        return {note_on_o[m], note_off_o[m], steal_o[m], fail_o[m], oerr_o[m]};
    endfunction

    function automatic logic [NV-1:0] mpack(input int m);
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = md_on[m][v];
        return r;
    endfunction

    task automatic chk(input string tag, input int m, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, m, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < NV; v++) begin
                md_on[m][v] = 1'b0; md_key[m][v] = 0; md_ch[m][v] = 0; md_age[m][v] = 0;
            end
            ep[m] = '0; e_adr[m] = 0; e_key[m] = 0; e_vel[m] = 0; e_ch[m] = 0;
        end
    endtask

    task automatic model_panic();
        for (int m = 0; m < 2; m++)
            for (int v = 0; v < NV; v++) md_on[m][v] = 1'b0;
    endtask

    // ep bit order: {note_on, note_off, steal, alloc_fail, off_note_error}
    task automatic model_apply(input int m, input bit is_off, input int ch,
                               input int key, input int vel, input logic [NV-1:0] free);
        int hit;
        int tgt;
        bit stl;
        hit = -1; tgt = -1; stl = 1'b0;
        ep[m] = '0;
        for (int v = 0; v < NV; v++)
            if (hit < 0 && md_on[m][v] && md_key[m][v] == key && md_ch[m][v] == ch) hit = v;
        if (is_off) begin
            if (hit >= 0) begin
                md_on[m][hit] = 1'b0;
                ep[m] = 5'b01000;
                e_adr[m] = hit; e_key[m] = key; e_vel[m] = vel; e_ch[m] = ch;
            end else begin
                ep[m] = 5'b00001;
            end
        end else begin
            if (hit >= 0) tgt = hit;
            else begin
                for (int v = 0; v < NV; v++)
                    if (tgt < 0 && !md_on[m][v] && free[v]) tgt = v;
                if (tgt < 0 && m == 0) begin
                    tgt = 0;
                    for (int v = 1; v < NV; v++)
                        if (md_age[m][v] > md_age[m][tgt]) tgt = v;
                    stl = md_on[m][tgt];
                end
            end
            if (tgt < 0) begin
                ep[m] = 5'b00010;
            end else begin
                for (int v = 0; v < NV; v++) begin
                    if (v == tgt) begin
                        md_on[m][v] = 1'b1; md_key[m][v] = key; md_ch[m][v] = ch;
                        md_age[m][v] = 0;
                    end else if (md_on[m][v] && md_age[m][v] < AGE_MAX) begin
                        md_age[m][v] = md_age[m][v] + 1;
                    end
                end
                ep[m] = {1'b1, 1'b0, stl, 2'b00};
                e_adr[m] = tgt; e_key[m] = key; e_vel[m] = vel; e_ch[m] = ch;
            end
        end
    endtask

    task automatic check_quiet(input string tag);
        for (int m = 0; m < 2; m++) chk(tag, m, pulses(m), 5'b0);
    endtask

    task automatic check_state(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_pulse"}, m, pulses(m), ep[m]);
            chk({tag, "_adr"},   m, adr_o[m],  e_adr[m]);
            chk({tag, "_key"},   m, kval_o[m], e_key[m]);
            chk({tag, "_vel"},   m, vel_o[m],  e_vel[m]);
            chk({tag, "_ch"},    m, ch_o[m],   e_ch[m]);
            chk({tag, "_gates"}, m, keys_o[m], mpack(m));
        end
    endtask

    // Called on a falling edge with both devices idle; returns on a falling edge.
    task automatic do_event(input string tag, input bit on, input bit off,
                            input int ch, input int key, input int vel,
                            input logic [NV-1:0] free, input bit panic_mid);
        int t;
        int exp_act [2];
        bit is_off;
        t = 0;
        while (evt_ready_o !== 2'b11 && t < 50) begin
            @(negedge reg_clk);
            t++;
        end
        for (int m = 0; m < 2; m++) chk({tag, "_ready"}, m, evt_ready_o[m], 1'b1);
        voice_free   = free;
        note_on_req  = on;
        note_off_req = off;
        evt_ch       = 2'(ch);
        evt_key      = 7'(key);
        evt_vel      = 7'(vel);
        @(negedge reg_clk);
        note_on_req  = 1'b0;
        note_off_req = 1'b0;
        for (int m = 0; m < 2; m++) chk({tag, "_busy"}, m, evt_ready_o[m], 1'b0);
        for (int c = 0; c < 5; c++) begin
            check_quiet({tag, "_scanquiet"});
            all_notes_off = (panic_mid && c == 1);
            @(negedge reg_clk);
        end
        all_notes_off = 1'b0;
        is_off = off || (on && vel == 0);
        for (int m = 0; m < 2; m++) model_apply(m, is_off, ch, key, vel, free);
        check_state(tag);
        for (int m = 0; m < 2; m++) exp_act[m] = $countones(mpack(m));
        if (panic_mid) model_panic();
        @(negedge reg_clk);
        check_quiet({tag, "_after"});
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_gates2"}, m, keys_o[m], mpack(m));
            chk({tag, "_active"}, m, act_o[m], exp_act[m]);
        end
        @(negedge reg_clk);
        for (int m = 0; m < 2; m++) chk({tag, "_active2"}, m, act_o[m], $countones(mpack(m)));
    endtask

    task automatic check_reset_values(input string tag);
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_pulse"},  m, pulses(m), 5'b0);
            chk({tag, "_gates"},  m, keys_o[m], '0);
            chk({tag, "_active"}, m, act_o[m], '0);
            chk({tag, "_cur"},    m, {adr_o[m], kval_o[m], vel_o[m], ch_o[m]}, '0);
            chk({tag, "_ready"},  m, evt_ready_o[m], 1'b1);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge reg_clk);
        reset_reg_N = 1'b0;
        model_reset();
        @(negedge reg_clk);
        check_reset_values(tag);
        reset_reg_N = 1'b1;
        @(negedge reg_clk);
    endtask

    task automatic panic_idle(input string tag);
        all_notes_off = 1'b1;
        note_on_req   = 1'b1;
        evt_ch        = 2'd0;
        evt_key       = 7'd65;
        evt_vel       = 7'd40;
        voice_free    = '1;
        @(negedge reg_clk);
        all_notes_off = 1'b0;
        note_on_req   = 1'b0;
        model_panic();
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_gates"}, m, keys_o[m], '0);
            chk({tag, "_ready"}, m, evt_ready_o[m], 1'b1);
        end
        for (int c = 0; c < 7; c++) begin
            check_quiet({tag, "_quiet"});
            @(negedge reg_clk);
        end
        for (int m = 0; m < 2; m++) begin
            chk({tag, "_gates2"}, m, keys_o[m], '0);
            chk({tag, "_active"}, m, act_o[m], '0);
        end
    endtask

    task automatic reset_mid_scan(input string tag);
        voice_free  = '1;
        note_on_req = 1'b1;
        evt_ch      = 2'd0;
        evt_key     = 7'd66;
        evt_vel     = 7'd50;
        @(negedge reg_clk);
        note_on_req = 1'b0;
        @(negedge reg_clk);
        #1 reset_reg_N = 1'b0;
        #1 model_reset();
        check_reset_values(tag);
        @(negedge reg_clk);
        reset_reg_N = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge reg_clk);
            check_quiet({tag, "_quiet"});
        end
        for (int m = 0; m < 2; m++) chk({tag, "_gates2"}, m, keys_o[m], '0);
    endtask

    initial begin
        compared      = 0;
        mismatched    = 0;
        reset_reg_N   = 1'b0;
        note_on_req   = 1'b0;
        note_off_req  = 1'b0;
        all_notes_off = 1'b0;
        evt_ch        = '0;
        evt_key       = '0;
        evt_vel       = '0;
        voice_free    = '1;
        model_reset();

        repeat (2) @(negedge reg_clk);
        check_reset_values("reset");
        reset_reg_N = 1'b1;
        @(negedge reg_clk);

        // First note, then fill and overflow the pool
        do_event("first_on", 1, 0, 0, 60, 100, 4'hF, 0);
        do_event("fill61",   1, 0, 0, 61, 90,  4'hF, 0);
        do_event("fill62",   1, 0, 0, 62, 80,  4'hF, 0);
        do_event("fill63",   1, 0, 0, 63, 70,  4'hF, 0);
        do_event("overflow", 1, 0, 0, 64, 60,  4'hF, 0);

        do_reset("reset2");
        do_event("c0k60",     1, 0, 0, 60, 100, 4'hF, 0);
        do_event("c1k60",     1, 0, 1, 60, 101, 4'hF, 0);
        do_event("retrigger", 1, 0, 0, 60, 102, 4'hF, 0);
        do_event("off_nomat", 0, 1, 2, 70, 10,  4'hF, 0);
        do_event("vel0_off",  1, 0, 0, 60, 0,   4'hF, 0);
        do_event("both_strb", 1, 1, 1, 60, 90,  4'hF, 0);
        do_event("busy_free", 1, 0, 2, 61, 33,  4'b0110, 0);
        do_event("panic_mid", 1, 0, 3, 61, 77,  4'hF, 1);
        do_event("pre_panic", 1, 0, 1, 62, 55,  4'hF, 0);
        panic_idle("panic_idle");
        do_event("pre_rst",   1, 0, 0, 62, 44,  4'hF, 0);
        reset_mid_scan("rst_mid");

        for (int i = 0; i < 90; i++) begin
            int r;
            int vel;
            logic [NV-1:0] fr;
            r   = int'($urandom_range(0, 9));
            vel = int'($urandom_range(1, 127));
            fr  = ($urandom_range(0, 2) == 0) ? NV'($urandom) : '1;
            if (r == 9) vel = 0;
            if (i % 23 == 22) panic_idle("rnd_panic");
            do_event("rnd", (r <= 5 || r >= 8), (r == 6 || r == 7 || r == 8),
                     int'($urandom_range(0, 3)), 60 + int'($urandom_range(0, 5)),
                     vel, fr, ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
